// File: rtl/fifo_stream_writer.sv
// Write-side packet producer for the async FIFO: queues source words, appends a
// length trailer after every packet and keeps write-side statistics.
module fifo_stream_writer #(
    parameter int WORD_SIZE = 8,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 wclk,
    input  logic                 rst,
    input  logic                 s_valid,
    input  logic [WORD_SIZE-1:0] s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    input  logic                 full,
    output logic                 wen,
    output logic [WORD_SIZE-1:0] w_word,
    output logic                 busy,
    output logic [CNT_SIZE-1:0]  word_count,
    output logic [CNT_SIZE-1:0]  pkt_count,
    output logic [CNT_SIZE-1:0]  stall_count
);

    typedef enum logic [1:0] {IDLE, DATA, TRAILER} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WORD_SIZE-1:0] r_q_word [2];
    logic                 r_q_trl  [2];
    logic [1:0]           r_qcnt;
    logic [WORD_SIZE-1:0] r_pkt_len;
    logic [CNT_SIZE-1:0]  r_word_count;
    logic [CNT_SIZE-1:0]  r_pkt_count;
    logic [CNT_SIZE-1:0]  r_stall_count;

    logic                 w_pop;
    logic                 w_accept;
    logic                 w_push_trl;
    logic                 w_push;
    logic [WORD_SIZE-1:0] w_push_word;
    logic [1:0]           w_wr_idx;
    logic [1:0]           w_qcnt_next;
    logic [WORD_SIZE-1:0] w_q_word_next [2];
    logic                 w_q_trl_next  [2];

    // Handshake depends on registers only, so full never reaches s_ready.
    assign s_ready     = (r_qcnt != 2'd2) && (r_state != TRAILER);
    assign wen         = (r_qcnt != 2'd0);
    assign w_word      = wen ? r_q_word[0] : '0;
    assign busy        = (r_state != IDLE) || (r_qcnt != 2'd0);
    assign word_count  = r_word_count;
    assign pkt_count   = r_pkt_count;
    assign stall_count = r_stall_count;

    assign w_pop       = wen && !full;
    assign w_accept    = s_valid && s_ready;
    // A full queue can still take the trailer when the head leaves on the same edge.
    assign w_push_trl  = (r_state == TRAILER) && ((r_qcnt != 2'd2) || w_pop);
    assign w_push      = w_accept || w_push_trl;
    assign w_push_word = w_push_trl ? r_pkt_len : s_data;
    assign w_wr_idx    = r_qcnt - {1'b0, w_pop};
    assign w_qcnt_next = r_qcnt + {1'b0, w_push} - {1'b0, w_pop};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = s_last ? TRAILER : DATA;
                end
            end
            DATA: begin
                if (w_accept && s_last) begin
                    w_state_next = TRAILER;
                end
            end
            TRAILER: begin
                if (w_push_trl) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_q_word_next[0] = r_q_word[0];
        w_q_word_next[1] = r_q_word[1];
        w_q_trl_next[0]  = r_q_trl[0];
        w_q_trl_next[1]  = r_q_trl[1];
        if (w_pop) begin
            w_q_word_next[0] = r_q_word[1];
            w_q_trl_next[0]  = r_q_trl[1];
        end
        if (w_push) begin
            if (w_wr_idx == 2'd0) begin
                w_q_word_next[0] = w_push_word;
                w_q_trl_next[0]  = w_push_trl;
            end else begin
                w_q_word_next[1] = w_push_word;
                w_q_trl_next[1]  = w_push_trl;
            end
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_qcnt  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_q_word[i] <= '0;
                r_q_trl[i]  <= 1'b0;
            end
        end else begin
            r_state <= w_state_next;
            r_qcnt  <= w_qcnt_next;
            for (int i = 0; i < 2; i++) begin
                r_q_word[i] <= w_q_word_next[i];
                r_q_trl[i]  <= w_q_trl_next[i];
            end
        end
    end

    // Length wraps at the word width, which is exactly the trailer encoding.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_pkt_len <= '0;
        end else if (w_push_trl) begin
            r_pkt_len <= '0;
        end else if (w_accept) begin
            r_pkt_len <= r_pkt_len + 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_word_count  <= '0;
            r_pkt_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_pop && !r_q_trl[0]) begin
                r_word_count <= r_word_count + 1'b1;
            end
            if (w_pop && r_q_trl[0]) begin
                r_pkt_count <= r_pkt_count + 1'b1;
            end
            if (wen && full) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Bench for fifo_stream_writer: directed cycle table, hand-written corner
// sequences and randomized packets checked against a packet-level model.
module tb_fifo_stream_writer;

    localparam int W = 8;
    localparam int C = 16;

    logic         wclk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_last;
    logic         s_ready;
    logic         full;
    logic         wen;
    logic [W-1:0] w_word;
    logic         busy;
    logic [C-1:0] word_count;
    logic [C-1:0] pkt_count;
    logic [C-1:0] stall_count;

    fifo_stream_writer #(.WORD_SIZE(W), .CNT_SIZE(C)) dut (
        .wclk(wclk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_last(s_last), .s_ready(s_ready), .full(full), .wen(wen),
        .w_word(w_word), .busy(busy), .word_count(word_count),
        .pkt_count(pkt_count), .stall_count(stall_count)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         l;
        logic         f;
        logic         e_wen;
        logic [W-1:0] e_word;
        logic         e_rdy;
        logic         e_busy;
    } vec_t;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];
    int           exp_words = 0;
    int           exp_pkts = 0;
    int           mon_stall = 0;
    int           low_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    // FIFO-side observer: records writes, counts stalls, checks hold-while-full.
    always @(negedge wclk) begin
        if (rst) begin
            prev_stall = 1'b0;
            mon_stall  = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_wen", 32'(wen), 32'd1);
                chk("hold_word", 32'(w_word), 32'(prev_word));
            end
            if (wen && !full) got_q.push_back(w_word);
            if (wen && full) mon_stall++;
            prev_stall = wen && full;
            prev_word  = w_word;
        end
    end

    task automatic send_word(input logic [W-1:0] d, input logic last,
                             input int p_full, input int p_gap);
        int tries = 0;
        bit done  = 1'b0;
        while (!done && tries < 200) begin
            full = ($urandom_range(99) < p_full);
            if ($urandom_range(99) < p_gap) begin
                s_valid = 1'b0;
                s_data  = W'($urandom);
                s_last  = 1'($urandom);
            end else begin
                s_valid = 1'b1;
                s_data  = d;
                s_last  = last;
                if (!s_ready) low_cnt++;
            end
            done = s_valid && s_ready;
            step();
            tries++;
        end
        chk("send_done", 32'(done), 32'd1);
    endtask

    task automatic drain_and_compare(input string name);
        int k = 0;
        full    = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        while (busy && k < 100) begin
            step();
            k++;
        end
        chk({name, "_drained"}, 32'(busy), 32'd0);
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({name, "_word_count"}, 32'(word_count), 32'(exp_words));
        chk({name, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts));
        chk({name, "_stall_count"}, 32'(stall_count), 32'(mon_stall));
        $display("%s: %0d words observed, word_count=%0d pkt_count=%0d stall_count=%0d",
                 name, got_q.size(), word_count, pkt_count, stall_count);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t tbl[8];
        int   sent;
        bit   acc;
        int   plen;
        logic [W-1:0] d;

        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; full = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word", 32'(w_word), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_pkt_count", 32'(pkt_count), 32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        rst = 1'b0;

        // Packet 11,22,33 then single-word packet 5A, cycle by cycle
        for (int i = 0; i < 8; i++) begin
            s_valid = tbl[i].v; s_data = tbl[i].d; s_last = tbl[i].l; full = tbl[i].f;
            chk($sformatf("tbl%0d_wen", i), 32'(wen), 32'(tbl[i].e_wen));
            chk($sformatf("tbl%0d_word", i), 32'(w_word), 32'(tbl[i].e_word));
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            $display("row %0d: v=%0d d=%h l=%0d -> wen=%0d w_word=%h s_ready=%0d busy=%0d",
                     i, tbl[i].v, tbl[i].d, tbl[i].l, wen, w_word, s_ready, busy);
            step();
        end
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h03, 8'h5A, 8'h01};
        exp_words += 4; exp_pkts += 2;
        drain_and_compare("table");

        // Stall: full held while words are offered
        full = 1'b1;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            s_valid = 1'b1; s_data = W'(8'hA0 + sent); s_last = 1'b0;
            if (c >= 2) begin
                chk($sformatf("stall_ready%0d", c), 32'(s_ready), 32'd0);
                chk($sformatf("stall_word%0d", c), 32'(w_word), 32'hA0);
            end
            acc = s_valid && s_ready;
            step();
            if (acc) sent++;
        end
        chk("stall_accepted", 32'(sent), 32'd2);
        chk("stall_cycles", 32'(stall_count), 32'd5);
        send_word(8'hA2, 1'b1, 0, 0);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'h03};
        exp_words += 3; exp_pkts += 1;
        drain_and_compare("stall");

        // 256-word packet: trailer wraps to zero
        for (int i = 0; i < 256; i++) begin
            send_word(W'(i), (i == 255), 0, 0);
            exp_q.push_back(W'(i));
        end
        exp_q.push_back(8'h00);
        exp_words += 256; exp_pkts += 1;
        drain_and_compare("long");

        // Back-to-back packets with s_valid held high
        low_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            send_word(W'(8'h40 + i), (i == 2), 0, 0);
            exp_q.push_back(W'(8'h40 + i));
        end
        exp_q.push_back(8'h03);
        for (int i = 0; i < 4; i++) begin
            send_word(W'(8'h50 + i), (i == 3), 0, 0);
            exp_q.push_back(W'(8'h50 + i));
        end
        exp_q.push_back(8'h04);
        chk("b2b_ready_low", 32'(low_cnt), 32'd1);
        chk("b2b_trailer_cycle", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        step();
        chk("b2b_ready_back", 32'(s_ready), 32'd1);
        exp_words += 7; exp_pkts += 2;
        drain_and_compare("b2b");

        // Reset mid-packet with words queued behind full
        send_word(8'hB1, 1'b0, 100, 0);
        send_word(8'hB2, 1'b0, 100, 0);
        s_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_wen", 32'(wen), 32'd0);
        chk("midrst_word", 32'(w_word), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd1);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        chk("midrst_pkt_count", 32'(pkt_count), 32'd0);
        chk("midrst_stall_count", 32'(stall_count), 32'd0);
        full = 1'b0;
        @(negedge wclk);
        #2 rst = 1'b0;
        got_q.delete();
        exp_q.delete();
        exp_words = 0; exp_pkts = 0;
        step();
        send_word(8'hC1, 1'b0, 0, 0);
        send_word(8'hC2, 1'b1, 0, 0);
        exp_q = '{8'hC1, 8'hC2, 8'h02};
        exp_words += 2; exp_pkts += 1;
        drain_and_compare("after_rst");

        // Randomized packets, source gaps and FIFO backpressure
        for (int p = 0; p < 40; p++) begin
            plen = $urandom_range(1, 12);
            for (int i = 0; i < plen; i++) begin
                d = W'($urandom);
                send_word(d, (i == plen - 1), 30, 25);
                exp_q.push_back(d);
            end
            exp_q.push_back(W'(plen));
            exp_words += plen; exp_pkts += 1;
        end
        drain_and_compare("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
